drp_responder: RTL

DRP_RESPONDER -- requirements
Module: drp_responder

---
 rtl/drp_responder.sv | 124 ++++++++++++
 1 files changed

// File: rtl/drp_responder.sv
// drp_responder: DRP slave with a fixed response latency, a small RW register
// file and a sticky error flag for requests that arrive while busy.
module drp_responder #(
    parameter int unsigned pLATENCY  = 2,
    parameter int unsigned pNUM_REGS = 16
) (
    input  logic        clk_usb,
    input  logic        reset_n,
    input  logic [6:0]  daddr_in,
    input  logic        den_in,
    input  logic        dwe_in,
    input  logic [15:0] di_in,
    output logic [15:0] do_out,
    output logic        drdy_out,
    output logic        err_o
);
    localparam int unsigned AW = (pNUM_REGS > 1) ? $clog2(pNUM_REGS) : 1;
    localparam logic [7:0]  NREGS  = 8'(pNUM_REGS);
    localparam logic [3:0]  LOAD   = 4'(pLATENCY - 1);
    localparam bit          DIRECT = (pLATENCY == 1);
    localparam logic [6:0]  A_STAT = 7'h40;
    localparam logic [6:0]  A_ECNT = 7'h41;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t        state_q;
    logic [3:0]    cnt_q;
    logic [6:0]    addr_q;
    logic          we_q;
    logic [15:0]   wdata_q;
    logic [15:0]   regs_q [2**AW];
    logic [7:0]    err_cnt_q;

    logic          accept;
    logic          collide;
    logic          commit;
    logic [6:0]    c_addr;
    logic          c_we;
    logic [15:0]   c_wdata;
    logic          c_hit;
    logic          c_clr;
    logic [AW-1:0] c_idx;
    logic [15:0]   rdata_d;

    assign accept  = den_in && (state_q != WAIT);
    assign collide = den_in && (state_q == WAIT);

    // Single-cycle latency commits on the accepting edge, so bypass the latches.
    assign c_addr  = DIRECT ? daddr_in : addr_q;
    assign c_we    = DIRECT ? dwe_in   : we_q;
    assign c_wdata = DIRECT ? di_in    : wdata_q;
    assign commit  = DIRECT ? accept : (state_q == WAIT && cnt_q == 4'd1);

    assign c_hit = {1'b0, c_addr} < NREGS;
    assign c_idx = c_addr[AW-1:0];
    assign c_clr = commit && c_we && (c_addr == A_ECNT);

    always_comb begin
        rdata_d = '0;
        unique case (1'b1)
            c_hit:              rdata_d = c_we ? c_wdata : regs_q[c_idx];
            (c_addr == A_STAT): rdata_d = c_we ? 16'h0 : {15'b0, err_o};
            (c_addr == A_ECNT): rdata_d = c_we ? 16'h0 : {8'b0, err_cnt_q};
            default:            rdata_d = '0;
        endcase
    end

    always_ff @(posedge clk_usb or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            drdy_out  <= 1'b0;
            do_out    <= '0;
            err_o     <= 1'b0;
            err_cnt_q <= '0;
            for (int i = 0; i < 2**AW; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            drdy_out <= commit;
            do_out   <= commit ? rdata_d : 16'h0;

            case (state_q)
                WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_q <= RESP;
                    end
                end
                default: begin
                    if (accept) begin
                        addr_q  <= daddr_in;
                        we_q    <= dwe_in;
                        wdata_q <= di_in;
                        cnt_q   <= LOAD;
                        state_q <= DIRECT ? RESP : WAIT;
                    end else begin
                        state_q <= IDLE;
                    end
                end
            endcase

            if (commit && c_we && c_hit) begin
                regs_q[c_idx] <= c_wdata;
            end

            // A collision on the same edge as a counter clear takes precedence.
            if (collide) begin
                err_o <= 1'b1;
                if (c_clr) begin
                    err_cnt_q <= 8'd1;
                end else if (err_cnt_q != 8'hFF) begin
                    err_cnt_q <= err_cnt_q + 8'd1;
                end
            end else if (c_clr) begin
                err_o     <= 1'b0;
                err_cnt_q <= '0;
            end
        end
    end
endmodule
